// File: rtl/cmp_pkg.sv
// Shared definitions for the chunk-serial comparator.
//   NEG, UNS, LT : bit positions inside the 3-bit instr field
//   cmp_state_t  : FSM state encoding (IDLE -> SCAN -> DONE -> IDLE)
package cmp_pkg;

    localparam int NEG = 2;   // invert the final outcome
    localparam int UNS = 1;   // 1 = unsigned operands, 0 = two's complement
    localparam int LT  = 0;   // 1 = less-than test, 0 = equality test

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/chunk_compare.sv
// Compares one chunk of two operands.
//   a, b : chunk bits of lhs and rhs
//   flip : invert the top bit of both chunks first, which turns an unsigned
//          compare into a two's-complement compare for the MSB chunk
//   eq   : chunks equal
//   lt   : a < b after the optional flip
module chunk_compare #(
    parameter int width = 4
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             flip,
    output logic             eq,
    output logic             lt
);

    localparam logic [width-1:0] TOP_BIT = width'(1) << (width - 1);

    logic [width-1:0] a_m;
    logic [width-1:0] b_m;

    assign a_m = a ^ (flip ? TOP_BIT : '0);
    assign b_m = b ^ (flip ? TOP_BIT : '0);
    assign eq  = (a_m == b_m);
    assign lt  = (a_m < b_m);

endmodule

// File: rtl/seq_comparator.sv
// Chunk-serial comparator with valid/ready handshakes on both sides.
// The operands are latched on accept and examined one chunk per cycle,
// MSB chunk first; the scan stops at the first differing chunk.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : request handshake (instr, lhs, rhs)
//   instr                 : [2] negate, [1] unsigned, [0] less-than (0 = equal)
//   flush                 : synchronous abort of any request or pending result
//   out_valid/out_ready   : result handshake
//   result                : zero-extended 1-bit outcome
//   scan_cycles           : chunks examined to reach the outcome
module seq_comparator
    import cmp_pkg::*;
#(
    parameter int data_size  = 16,
    parameter int chunk_size = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [2:0]                                 instr,
    input  logic [data_size-1:0]                       lhs,
    input  logic [data_size-1:0]                       rhs,
    input  logic                                       flush,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [data_size-1:0]                       result,
    output logic [$clog2(data_size/chunk_size):0]      scan_cycles
);

    localparam int NCHUNKS = data_size / chunk_size;
    localparam int SC_W    = $clog2(NCHUNKS) + 1;
    // At least one bit so the single-chunk configuration still has an index.
    localparam int IDX_W   = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNKS - 1);

    cmp_state_t          state_reg,  state_next;
    logic [2:0]          instr_reg,  instr_next;
    logic [data_size-1:0] lhs_reg,   lhs_next;
    logic [data_size-1:0] rhs_reg,   rhs_next;
    logic [IDX_W-1:0]    idx_reg,    idx_next;
    logic [data_size-1:0] result_reg, result_next;
    logic [SC_W-1:0]     scan_reg,   scan_next;

    logic chunk_eq;
    logic chunk_lt;
    logic flip;
    logic outcome_lt;
    logic outcome_eq;

    // The latched operands are shifted left one chunk per cycle, so the
    // chunk under test always sits in the top chunk_size bits.
    assign flip = (idx_reg == '0) && !instr_reg[UNS];

    chunk_compare #(
        .width (chunk_size)
    ) u_chunk (
        .a    (lhs_reg[data_size-1 -: chunk_size]),
        .b    (rhs_reg[data_size-1 -: chunk_size]),
        .flip (flip),
        .eq   (chunk_eq),
        .lt   (chunk_lt)
    );

    // When every chunk matched, chunk_lt is 0 and chunk_eq is 1, which is
    // exactly "not less" / "equal", so the same expressions cover both exits.
    assign outcome_lt = chunk_lt;
    assign outcome_eq = chunk_eq;

    always_comb begin
        state_next  = state_reg;
        instr_next  = instr_reg;
        lhs_next    = lhs_reg;
        rhs_next    = rhs_reg;
        idx_next    = idx_reg;
        result_next = result_reg;
        scan_next   = scan_reg;

        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    instr_next = instr;
                    lhs_next   = lhs;
                    rhs_next   = rhs;
                    idx_next   = '0;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!chunk_eq || (idx_reg == LAST_IDX)) begin
                    result_next = {{(data_size-1){1'b0}},
                                   instr_reg[NEG] ^ (instr_reg[LT] ? outcome_lt : outcome_eq)};
                    scan_next   = SC_W'(idx_reg) + SC_W'(1);
                    state_next  = ST_DONE;
                end else begin
                    lhs_next = lhs_reg << chunk_size;
                    rhs_next = rhs_reg << chunk_size;
                    idx_next = idx_reg + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Abort wins over both handshakes; the held result is simply
        // abandoned since out_valid is derived from the state.
        if (flush) begin
            state_next = ST_IDLE;
            idx_next   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            instr_reg  <= '0;
            lhs_reg    <= '0;
            rhs_reg    <= '0;
            idx_reg    <= '0;
            result_reg <= '0;
            scan_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            instr_reg  <= instr_next;
            lhs_reg    <= lhs_next;
            rhs_reg    <= rhs_next;
            idx_reg    <= idx_next;
            result_reg <= result_next;
            scan_reg   <= scan_next;
        end
    end

    assign in_ready    = (state_reg == ST_IDLE);
    assign out_valid   = (state_reg == ST_DONE);
    assign result      = result_reg;
    assign scan_cycles = scan_reg;

endmodule
